// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and small decode helpers for the PS/2 key tracker.
package ps2_pkg;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] PFX_BREAK = 8'hF0;
    localparam logic [7:0] PFX_EXT   = 8'hE0;

    localparam logic [7:0] ARR_UP    = 8'h75;
    localparam logic [7:0] ARR_LEFT  = 8'h6B;
    localparam logic [7:0] ARR_DOWN  = 8'h72;
    localparam logic [7:0] ARR_RIGHT = 8'h74;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_IDLE, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;

    function automatic logic [3:0] key_bit(input logic [7:0] b);
        case (b)
            KEY_W:   key_bit = 4'b1000;
            KEY_A:   key_bit = 4'b0100;
            KEY_S:   key_bit = 4'b0010;
            KEY_D:   key_bit = 4'b0001;
            default: key_bit = 4'b0000;
        endcase
    endfunction

    // Remaining held key that takes over keycode: D > A > W > S.
    function automatic logic [7:0] priority_key(input logic [3:0] held);
        if (held[0]) begin
            priority_key = KEY_D;
        end else if (held[2]) begin
            priority_key = KEY_A;
        end else if (held[3]) begin
            priority_key = KEY_W;
        end else begin
            priority_key = KEY_S;
        end
    endfunction

    function automatic logic odd_parity_ok(input logic [8:0] v);
        odd_parity_ok = ^v;
    endfunction

    // Arrow key to game key alias; 8'h00 means "not an aliased key".
    function automatic logic [7:0] ext_alias(input logic [7:0] b);
        case (b)
            ARR_UP:    ext_alias = KEY_W;
            ARR_LEFT:  ext_alias = KEY_A;
            ARR_DOWN:  ext_alias = KEY_S;
            ARR_RIGHT: ext_alias = KEY_D;
            default:   ext_alias = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, 11-bit frame FSM
// with parity/stop checking and a mid-frame inactivity timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o,
    output logic       timeout_o
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, fall_q;
    logic [FW-1:0] filt_cnt_q;
    rx_state_t     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d, err_q, err_d, tout_q, tout_d;
    logic [7:0]    data_q, data_d;
    logic          clk_s, dat_s;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Two-flop synchronizers (idle-high) and the PS2 clock level filter with fall pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            fall_q     <= 1'b0;
            if (clk_s == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q     <= clk_s;
                filt_cnt_q <= '0;
                fall_q     <= filt_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    // Frame FSM next state, timeout counting and registered result pulses.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        tout_d   = 1'b0;
        if (state_q == RX_IDLE || fall_q) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = '0;
            err_d   = 1'b1;
            tout_d  = 1'b1;
            state_d = RX_IDLE;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        if (fall_q) begin
            case (state_q)
                RX_IDLE: begin
                    if (!dat_s) begin
                        state_d  = RX_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    shift_d = {dat_s, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    par_d   = dat_s;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (odd_parity_ok({par_q, shift_q}) && dat_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else begin
            shift_d = shift_q;
        end
    end

    // Frame FSM state and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            tout_q   <= tout_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign frame_err_o  = err_q;
    assign timeout_o    = tout_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: make/break/extended decoding and game-key hold tracking.
// Optional macro PS2_EXT_KEYS_EN aliases the arrow keys onto W/A/S/D.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       keyPress,
    output logic [3:0] KeyHeld,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       frameErr
);

    logic       rx_timeout_s;
    dec_state_t dec_q, dec_d;
    logic [7:0] keycode_q, keycode_d;
    logic       press_q, press_d;
    logic [3:0] held_q, held_d;
    logic       do_make_s, do_break_s;
    logic [7:0] code_s, ext_code_s;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i       (Clk),
        .rst_n_i     (Reset),
        .ps2_clk_i   (PS2_CLK),
        .ps2_dat_i   (PS2_DAT),
        .byte_valid_o(byteValid),
        .byte_data_o (byteData),
        .frame_err_o (frameErr),
        .timeout_o   (rx_timeout_s)
    );

    // Sequence decoder plus make/break effect on keycode, keyPress and the held bitmap.
    always_comb begin
        dec_d      = dec_q;
        keycode_d  = keycode_q;
        press_d    = press_q;
        held_d     = held_q;
        do_make_s  = 1'b0;
        do_break_s = 1'b0;
        code_s     = byteData;
`ifdef PS2_EXT_KEYS_EN
        ext_code_s = ext_alias(byteData);
`else
        ext_code_s = 8'h00;
`endif
        if (rx_timeout_s) begin
            dec_d = DEC_IDLE;
        end else if (byteValid) begin
            case (dec_q)
                DEC_IDLE: begin
                    if (byteData == PFX_BREAK) begin
                        dec_d = DEC_BREAK;
                    end else if (byteData == PFX_EXT) begin
                        dec_d = DEC_EXT;
                    end else begin
                        do_make_s = 1'b1;
                    end
                end
                DEC_BREAK: begin
                    do_break_s = 1'b1;
                    dec_d      = DEC_IDLE;
                end
                DEC_EXT: begin
                    if (byteData == PFX_BREAK) begin
                        dec_d = DEC_EXT_BREAK;
                    end else begin
                        do_make_s = (ext_code_s != 8'h00);
                        code_s    = ext_code_s;
                        dec_d     = DEC_IDLE;
                    end
                end
                DEC_EXT_BREAK: begin
                    do_break_s = (ext_code_s != 8'h00);
                    code_s     = ext_code_s;
                    dec_d      = DEC_IDLE;
                end
                default: dec_d = DEC_IDLE;
            endcase
        end else begin
            dec_d = dec_q;
        end

        if (do_make_s) begin
            held_d = held_q | key_bit(code_s);
            if (code_s != keycode_q || !press_q) begin
                keycode_d = code_s;
                press_d   = 1'b1;
            end else begin
                press_d = press_q;
            end
        end else if (do_break_s) begin
            held_d = held_q & ~key_bit(code_s);
            if (code_s == keycode_q && held_d != 4'b0000) begin
                keycode_d = priority_key(held_d);
            end else if (code_s == keycode_q) begin
                press_d = 1'b0;
            end else begin
                press_d = press_q;
            end
        end else begin
            held_d = held_q;
        end
    end

    // Decoder state and registered key outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dec_q     <= DEC_IDLE;
            keycode_q <= 8'h00;
            press_q   <= 1'b0;
            held_q    <= 4'b0000;
        end else begin
            dec_q     <= dec_d;
            keycode_q <= keycode_d;
            press_q   <= press_d;
            held_q    <= held_d;
        end
    end

    assign keycode  = keycode_q;
    assign keyPress = press_q;
    assign KeyHeld  = held_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker (works with or without PS2_EXT_KEYS_EN).
module tb_ps2_key_tracker;

    localparam int HALF = 20;
    localparam int TMO  = 2000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] keycode, byteData;
    logic       keyPress, byteValid, frameErr;
    logic [3:0] KeyHeld;

    int checks = 0;
    int failures = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    int kc_chg = 0;
    int bv_mark, fe_mark, chg_mark;
    logic [7:0] last_byte = 8'h00, kc_at_bv = 8'h00, kc_after_bv = 8'h00, kc_prev = 8'h00;
    logic       bv_d1 = 1'b0;

    always #5 Clk = ~Clk;

    ps2_key_tracker #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .keycode(keycode), .keyPress(keyPress), .KeyHeld(KeyHeld),
        .byteValid(byteValid), .byteData(byteData), .frameErr(frameErr)
    );

    always @(negedge Clk) begin
        bv_d1   <= byteValid;
        kc_prev <= keycode;
        if (byteValid) begin
            bv_cnt    <= bv_cnt + 1;
            last_byte <= byteData;
            kc_at_bv  <= keycode;
        end
        if (bv_d1) kc_after_bv <= keycode;
        if (frameErr) fe_cnt <= fe_cnt + 1;
        if (keycode !== kc_prev) kc_chg <= kc_chg + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        wait_clk(HALF);
        PS2_CLK = 1'b0;
        wait_clk(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par_ok ? ~^d : ^d);
        ps2_bit(stop);
        PS2_DAT = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(1'b1);
        PS2_DAT = 1'b1;
    endtask

    task automatic check_keys(input string tag, input logic [7:0] kc, input logic kp, input logic [3:0] kh);
        check({tag, "_keycode"}, 32'(keycode), 32'(kc));
        check({tag, "_keyPress"}, 32'(keyPress), 32'(kp));
        check({tag, "_KeyHeld"}, 32'(KeyHeld), 32'(kh));
    endtask

    initial begin
        // reset state
        wait_clk(4);
        check_keys("reset", 8'h00, 1'b0, 4'b0000);
        check("reset_byteValid", 32'(byteValid), 32'd0);
        check("reset_byteData", 32'(byteData), 32'h00);
        check("reset_frameErr", 32'(frameErr), 32'd0);
        Reset = 1'b1;
        wait_clk(4);

        // 1: single good frame 1C, one-cycle decode latency
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t1_bv_cnt", 32'(bv_cnt), 32'd1);
        check("t1_byteData", 32'(last_byte), 32'h1C);
        check("t1_kc_at_bv", 32'(kc_at_bv), 32'h00);
        check("t1_kc_after_bv", 32'(kc_after_bv), 32'h1C);
        check_keys("t1", 8'h1C, 1'b1, 4'b0100);

        // 2: multi-key hold and release with priority fallback
        send_frame(8'h23, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check_keys("t2_relA", 8'h23, 1'b1, 4'b0001);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h23, 1'b1, 1'b1);
        check_keys("t2_relD", 8'h23, 1'b0, 4'b0000);
        send_frame(8'h1B, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check_keys("t2_prioW", 8'h1D, 1'b1, 4'b1010);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
        check_keys("t2_relOther", 8'h1D, 1'b1, 4'b1000);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b1, 1'b1);
        check_keys("t2_relW", 8'h1D, 1'b0, 4'b0000);
        check("t2_bv_cnt", 32'(bv_cnt), 32'd16);

        // 3: parity and stop errors
        send_frame(8'h1D, 1'b0, 1'b1);
        check("t3_par_fe", 32'(fe_cnt), 32'd1);
        send_frame(8'h1D, 1'b1, 1'b0);
        check("t3_stop_fe", 32'(fe_cnt), 32'd2);
        check("t3_bv_cnt", 32'(bv_cnt), 32'd16);
        check_keys("t3", 8'h1D, 1'b0, 4'b0000);

        // 4: mid-frame timeout, boundary and recovery
        send_partial(5);
        wait_clk(TMO - 100);
        check("t4_no_early_tmo", 32'(fe_cnt), 32'd2);
        wait_clk(300);
        check("t4_tmo_fe", 32'(fe_cnt), 32'd3);
        send_frame(8'h1B, 1'b1, 1'b1);
        check_keys("t4_after", 8'h1B, 1'b1, 4'b0010);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_partial(3);
        wait_clk(TMO + 200);
        check("t4_tmo2_fe", 32'(fe_cnt), 32'd4);
        send_frame(8'h1C, 1'b1, 1'b1);
        check_keys("t4_dec_reset", 8'h1C, 1'b1, 4'b0110);

        // 5: short clock glitch rejected, typematic repeats
        bv_mark = bv_cnt;
        PS2_DAT = 1'b0;
        PS2_CLK = 1'b0;
        wait_clk(3);
        PS2_CLK = 1'b1;
        wait_clk(2);
        PS2_DAT = 1'b1;
        wait_clk(TMO + 100);
        check("t5_glitch_fe", 32'(fe_cnt), 32'd4);
        check("t5_glitch_bv", 32'(bv_cnt), 32'(bv_mark));
        chg_mark = kc_chg;
        for (int i = 0; i < 4; i++) send_frame(8'h1D, 1'b1, 1'b1);
        check("t5_kc_changes", 32'(kc_chg - chg_mark), 32'd1);
        check_keys("t5_repeat", 8'h1D, 1'b1, 4'b1110);

        // 6: extended arrow sequences
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
        check_keys("t6_clear", 8'h1B, 1'b0, 4'b0000);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
`ifdef PS2_EXT_KEYS_EN
        check_keys("t6_ext_make", 8'h1D, 1'b1, 4'b1000);
`else
        check_keys("t6_ext_make", 8'h1B, 1'b0, 4'b0000);
`endif
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
`ifdef PS2_EXT_KEYS_EN
        check_keys("t6_ext_break", 8'h1D, 1'b0, 4'b0000);
`else
        check_keys("t6_ext_break", 8'h1B, 1'b0, 4'b0000);
`endif
        send_frame(8'h1C, 1'b1, 1'b1);
        check_keys("t6_follow", 8'h1C, 1'b1, 4'b0100);
        send_frame(8'h75, 1'b1, 1'b1);
        check_keys("t6_nongame", 8'h75, 1'b1, 4'b0100);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check_keys("t6_brk_other", 8'h75, 1'b1, 4'b0000);
        check("t6_bv_cnt", 32'(bv_cnt), 32'd38);

        // mid-frame reset discards the partial frame
        bv_mark = bv_cnt;
        fe_mark = fe_cnt;
        send_partial(4);
        Reset = 1'b0;
        wait_clk(3);
        check_keys("rst_mid", 8'h00, 1'b0, 4'b0000);
        Reset = 1'b1;
        wait_clk(TMO + 100);
        check("rst_mid_bv", 32'(bv_cnt), 32'(bv_mark));
        check("rst_mid_fe", 32'(fe_cnt), 32'(fe_mark));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
